// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit multiplexed 7-segment driver: segment ROM,
// blank/off codes and the anode-select helper.
package seg7_pkg;

  localparam int NDIG = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam logic [6:0] SEG_ROM [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef logic [1:0] dig_idx_t;

  function automatic logic [3:0] anode_for(input dig_idx_t idx);
    logic [3:0] a;
    a = AN_OFF;
    a[2'd3 - idx] = 1'b0;
    return a;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment pattern lookup.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_ROM[nib];

endmodule

// File: rtl/seg7_scan_driver.sv
// 4-digit common-anode 7-segment scan driver with per-frame snapshot of dataBus.
// Optional leading-zero blanking when SEG7_LZ_BLANK_EN is defined.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] dataBus,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int            PW      = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PRE_ONE = PW'(1);

  logic [PW-1:0] pre_r;
  dig_idx_t      idx_r;
  logic [15:0]   snap_r;
  logic [3:0]    an_r;
  logic [6:0]    seg_r;
  logic          dp_r;
  logic          frame_done_r;

  logic          tick_s;
  dig_idx_t      idx_next_s;
  logic [3:0]    nib_s;
  logic [6:0]    dec_s;
  logic [3:0]    blank_s;
  logic [3:0]    an_next_s;
  logic [6:0]    seg_next_s;

  // Slot-end strobe and next digit index.
  always_comb begin
    tick_s     = en && (pre_r == PRE_MAX);
    idx_next_s = idx_r + 2'd1;
  end

  // Select the snapshot nibble for the digit currently being scanned.
  always_comb begin
    nib_s = 4'h0;
    case (idx_r)
      2'd0:    nib_s = snap_r[15:12];
      2'd1:    nib_s = snap_r[11:8];
      2'd2:    nib_s = snap_r[7:4];
      default: nib_s = snap_r[3:0];
    endcase
  end

  hex_to_seg7 u_dec (
    .nib (nib_s),
    .seg (dec_s)
  );

`ifdef SEG7_LZ_BLANK_EN
  // A digit is blanked only if it and every digit to its left are zero.
  always_comb begin
    blank_s    = 4'b0000;
    blank_s[0] = (snap_r[15:12] == 4'h0);
    blank_s[1] = (snap_r[15:12] == 4'h0) && (snap_r[11:8] == 4'h0);
    blank_s[2] = (snap_r[15:12] == 4'h0) && (snap_r[11:8] == 4'h0)
                 && (snap_r[7:4] == 4'h0);
    blank_s[3] = 1'b0;
  end
`else
  assign blank_s = 4'b0000;
`endif

  // Next anode/segment values; dark whenever scanning is disabled.
  always_comb begin
    an_next_s  = AN_OFF;
    seg_next_s = SEG_BLANK;
    if (en) begin
      an_next_s  = anode_for(idx_r);
      seg_next_s = blank_s[idx_r] ? SEG_BLANK : dec_s;
    end else begin
      an_next_s  = AN_OFF;
      seg_next_s = SEG_BLANK;
    end
  end

  // Prescaler, digit index and frame snapshot.
  always_ff @(posedge clk) begin
    if (!clr) begin
      pre_r  <= '0;
      idx_r  <= 2'd3;
      snap_r <= 16'h0000;
    end else if (tick_s) begin
      pre_r <= '0;
      idx_r <= idx_next_s;
      if (idx_next_s == 2'd0) begin
        snap_r <= dataBus;
      end
    end else if (en) begin
      pre_r <= pre_r + PRE_ONE;
    end
  end

  // Registered display outputs; an and seg change on the same edge.
  always_ff @(posedge clk) begin
    if (!clr) begin
      an_r         <= AN_OFF;
      seg_r        <= SEG_BLANK;
      dp_r         <= 1'b1;
      frame_done_r <= 1'b0;
    end else begin
      an_r         <= an_next_s;
      seg_r        <= seg_next_s;
      dp_r         <= 1'b1;
      frame_done_r <= tick_s && (idx_r == 2'd3);
    end
  end

  assign an         = an_r;
  assign seg        = seg_r;
  assign dp         = dp_r;
  assign frame_done = frame_done_r;

endmodule
